poly_job_sequencer: RTL and testbench
=====================================

// Module: poly_job_sequencer
// PURPOSE
//  Upstream feeder and result collector for the polynomial datapath (BC/BO pair).
//  Holds coefficients A/B/C in config registers and buffers incoming x samples in a small FIFO.
//  Launches one evaluation per sample with a 1-cycle inicio pulse and waits a fixed CALC_CYCLES.
//  Then captures resultado and presents it on a valid/ready output port.
// PARAMETERS
//  W           16  data width of x, coefficients, result
//  CALC_CYCLES 8   cycles from the inicio cycle's end to resultado being stable (>=1)
//  FIFO_DEPTH  4   x-sample FIFO entries (power of 2, >=2)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous, active-low reset
//  cfg_we    in   1      coefficient write strobe
//  cfg_addr  in   2      0=A 1=B 2=C 3=reserved (write ignored, no error)
//  cfg_data  in   W      coefficient write data
//  cfg_err   out  1      1-cycle pulse: write rejected because block not IDLE
//  x_valid   in   1      sample valid
//  x_ready   out  1      FIFO not full
//  x_data    in   W      sample value
//  inicio    out  1      start pulse to datapath controller
//  x_out     out  W      sample under evaluation (stable START..HOLD)
//  A_out/B_out/C_out out W  coefficient registers to datapath
//  resultado in   W      datapath result
//  y_valid   out  1      result valid
//  y_ready   in   1      consumer ready
//  y_data    out  W      captured result
//  busy      out  1      state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, FIFO emptied, all outputs 0 (x_ready=1 once rst=1).
//  Reset mid-job aborts the job. The sample in flight is lost and no y_valid is produced.
//  FIFO: push on x_valid&&x_ready. Pop only in IDLE when count>0, evaluated pre-edge.
//  A push into an empty FIFO is not popped in the same cycle.
//  Capacity is FIFO_DEPTH queued plus 1 in x_out.
//  FSM:
//   IDLE  : count>0 -> pop head into x_out, go START
//   START : inicio=1 (only state where it is 1); cnt<=CALC_CYCLES; go WAIT
//   WAIT  : cnt decrements each cycle; on cnt==1 -> y_data<=resultado, y_valid<=1, go HOLD
//           WAIT lasts exactly CALC_CYCLES cycles
//   HOLD  : y_valid=1, y_data/x_out stable; y_valid&&y_ready -> y_valid<=0, go IDLE
//  Latency: y_valid rises CALC_CYCLES+1 edges after the IDLE->START edge.
//  Minimum job period is CALC_CYCLES+3 cycles (y_ready tied 1).
//  Config writes:
//   - Accepted only in IDLE, written at the edge.
//   - In any other state: register unchanged, cfg_err=1 for one cycle.
//   - Write in the same IDLE cycle as a pop: accepted; the new value applies to that job.
//  Arithmetic: none in this block. Values pass through unmodified at W bits.
//  No protocol violation: y_data never changes while y_valid=1 && !y_ready.
// TESTING (bench uses behavioural datapath stub: resultado=A*x*x+B*x+C mod 2^W,
//          valid CALC_CYCLES after inicio)
//  1 Assert rst=0 mid-run -> all outputs 0, x_ready=1 after release, busy=0.
//  2 Write A=1,B=2,C=2; push x=2 -> single inicio pulse; y_valid at pop-edge+9 (CALC_CYCLES=8).
//    Expect y_data=10.
//  3 As 2 with y_ready=0 for 5 cycles -> y_data=10 held, y_valid stays 1, no second inicio.
//    Then y_ready=1 -> IDLE.
//  4 y_ready=0; push x=1..6 back-to-back -> x=1 in flight, x=2..5 queued.
//    x_ready=0, x=6 not accepted until y handshake.
//    Results in order 5,10,17,26,37 (A=1,B=2,C=2).
//  5 cfg_we with addr=0, data=7 during WAIT -> cfg_err pulse, A_out unchanged.
//    Same write in IDLE -> A_out=7, no cfg_err.
//    addr=3 in IDLE -> nothing changes, no cfg_err.
//  6 rst=0 for 1 cycle during WAIT of x=3 -> no y_valid for it.
//    Next push x=0 -> y_data=C (2) at the normal latency.

Source files
------------

// File: rtl/poly_job_sequencer_if.sv
// Handshake and data bundle between the job sequencer and its neighbours:
// config port, x-sample stream in, datapath launch/result, y-result stream out.
interface poly_job_sequencer_if #(
    parameter int W = 16
);
    logic         cfg_we;
    logic [1:0]   cfg_addr;
    logic [W-1:0] cfg_data;
    logic         cfg_err;
    logic         x_valid;
    logic         x_ready;
    logic [W-1:0] x_data;
    logic         inicio;
    logic [W-1:0] x_out;
    logic [W-1:0] A_out;
    logic [W-1:0] B_out;
    logic [W-1:0] C_out;
    logic [W-1:0] resultado;
    logic         y_valid;
    logic         y_ready;
    logic [W-1:0] y_data;
    logic         busy;

    // Environment side: drives config, samples, datapath result and consumer ready
    modport master (
        output cfg_we, cfg_addr, cfg_data, x_valid, x_data, resultado, y_ready,
        input  cfg_err, x_ready, inicio, x_out, A_out, B_out, C_out, y_valid, y_data, busy
    );

    // Sequencer side
    modport slave (
        input  cfg_we, cfg_addr, cfg_data, x_valid, x_data, resultado, y_ready,
        output cfg_err, x_ready, inicio, x_out, A_out, B_out, C_out, y_valid, y_data, busy
    );
endinterface

// File: rtl/poly_job_sequencer.sv
// Feeds x samples from a small FIFO to the polynomial datapath one job at a
// time, waits a fixed number of cycles, then presents the captured result on
// a valid/ready port. Coefficient registers are writable only while idle.
module poly_job_sequencer #(
    parameter int W           = 16,
    parameter int CALC_CYCLES = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    poly_job_sequencer_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CALC_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

    state_t          state_q;
    logic [W-1:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    a_q, b_q, c_q, x_out_q, y_data_q;
    logic            inicio_q, cfg_err_q, y_valid_q;
    logic            push, pop;

    // x_ready is held low while in reset so nothing is accepted then
    assign bus.x_ready = rst_ni && (count_q != (AW+1)'(FIFO_DEPTH));
    assign push        = bus.x_valid && bus.x_ready;
    // Pop looks at the pre-edge count, so a push into an empty FIFO waits a cycle
    assign pop         = (state_q == IDLE) && (count_q != '0);

    assign bus.inicio  = inicio_q;
    assign bus.cfg_err = cfg_err_q;
    assign bus.x_out   = x_out_q;
    assign bus.A_out   = a_q;
    assign bus.B_out   = b_q;
    assign bus.C_out   = c_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_data  = y_data_q;
    assign bus.busy    = (state_q != IDLE) || (count_q != '0);

    // Occupancy next-state from the push/pop pair
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push && pop) count_d = count_q - (AW+1)'(1);
    end

    // Sample storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= bus.x_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Job FSM, coefficient registers and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            inicio_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            x_out_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
        end else begin
            // Writes land only while idle; a write on the pop cycle feeds that job
            cfg_err_q <= bus.cfg_we && (state_q != IDLE);
            if (bus.cfg_we && state_q == IDLE) begin
                case (bus.cfg_addr)
                    2'd0:    a_q <= bus.cfg_data;
                    2'd1:    b_q <= bus.cfg_data;
                    2'd2:    c_q <= bus.cfg_data;
                    default: ;
                endcase
            end
            inicio_q <= 1'b0;
            case (state_q)
                IDLE: if (pop) begin
                    x_out_q  <= fifo_q[rd_ptr_q];
                    inicio_q <= 1'b1;
                    state_q  <= START;
                end
                START: begin
                    cnt_q   <= CW'(CALC_CYCLES);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        y_data_q  <= bus.resultado;
                        y_valid_q <= 1'b1;
                        state_q   <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: if (bus.y_ready) begin
                    y_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_job_sequencer.sv
// Bench for poly_job_sequencer: datapath stub, job-level reference model with
// a per-cycle compare, directed scenarios with literal results, random traffic.
module tb_poly_job_sequencer;
    localparam int W  = 16;
    localparam int CC = 8;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nmis = 0;

    poly_job_sequencer_if #(.W(W)) bus();

    poly_job_sequencer #(.W(W), .CALC_CYCLES(CC), .FIFO_DEPTH(D)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] poly(logic [W-1:0] x, logic [W-1:0] a,
                                          logic [W-1:0] b, logic [W-1:0] c);
        return a * x * x + b * x + c;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Datapath stub: result is only correct on the cycle the sequencer should capture it
    logic [W-1:0] pend = '0;
    int           k = 0;
    always @(posedge clk) begin
        if (bus.inicio) begin
            pend <= poly(bus.x_out, bus.A_out, bus.B_out, bus.C_out);
            k    <= CC;
        end else if (k > 0) begin
            k <= k - 1;
        end
    end
    assign bus.resultado = (k == 1) ? pend : ~pend;

    // Reference model: a job is alive from launch; age counts edges since launch.
    // Age 0 is the launch cycle, result appears CC+1 edges later and is held until taken.
    logic [W-1:0] mq[$];
    bit           job = 0, eyv = 0, eerr = 0;
    int           age = 0, pre = 0;
    logic [W-1:0] mA = '0, mB = '0, mC = '0, mx = '0, eyd = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            job = 0; eyv = 0; eerr = 0; age = 0;
            mA = '0; mB = '0; mC = '0; mx = '0; eyd = '0;
        end else begin
            pre  = mq.size();
            eerr = 0;
            if (bus.cfg_we) begin
                if (job) eerr = 1;
                else if (bus.cfg_addr == 2'd0) mA = bus.cfg_data;
                else if (bus.cfg_addr == 2'd1) mB = bus.cfg_data;
                else if (bus.cfg_addr == 2'd2) mC = bus.cfg_data;
            end
            if (job) begin
                if (age >= CC + 1) begin
                    if (bus.y_ready) begin job = 0; eyv = 0; end
                end else begin
                    age++;
                    if (age == CC + 1) begin eyv = 1; eyd = poly(mx, mA, mB, mC); end
                end
            end else if (pre > 0) begin
                mx = mq.pop_front(); job = 1; age = 0;
            end
            if (bus.x_valid && pre < D) mq.push_back(bus.x_data);
        end
    end

    // Per-cycle compare of every output against the model
    int n_inicio = 0, nyv = 0;
    logic [W-1:0] got[$];
    always @(negedge clk) begin
        chk("inicio",  32'(bus.inicio),  32'(job && age == 0));
        chk("x_ready", 32'(bus.x_ready), 32'(rst_n && mq.size() < D));
        chk("busy",    32'(bus.busy),    32'(job || mq.size() > 0));
        chk("y_valid", 32'(bus.y_valid), 32'(eyv));
        chk("y_data",  32'(bus.y_data),  32'(eyd));
        chk("cfg_err", 32'(bus.cfg_err), 32'(eerr));
        chk("x_out",   32'(bus.x_out),   32'(mx));
        chk("A_out",   32'(bus.A_out),   32'(mA));
        chk("B_out",   32'(bus.B_out),   32'(mB));
        chk("C_out",   32'(bus.C_out),   32'(mC));
        if (bus.inicio) n_inicio++;
        if (bus.y_valid) nyv++;
        if (bus.y_valid && bus.y_ready) got.push_back(bus.y_data);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(logic [1:0] a, logic [W-1:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic push(logic [W-1:0] x);
        bit rdy, done;
        done = 0;
        bus.x_valid = 1'b1; bus.x_data = x;
        for (int i = 0; i < 300; i++) begin
            rdy = bus.x_ready;
            step();
            if (rdy) begin done = 1; break; end
        end
        bus.x_valid = 1'b0;
        if (!done) chk("push_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_yv(output int n);
        n = 0;
        while (!bus.y_valid && n < 100) begin step(); n++; end
        if (n >= 100) chk("yv_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 500) begin step(); n++; end
        if (n >= 500) chk("idle_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int n, i0, n0;
        int exp4[6];
        exp4 = '{5, 10, 17, 26, 37, 50};
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.x_valid = 0; bus.x_data = '0; bus.y_ready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_x_ready", 32'(bus.x_ready), 32'(0));
        chk("rst_busy",    32'(bus.busy),    32'(0));
        chk("rst_y_valid", 32'(bus.y_valid), 32'(0));
        chk("rst_inicio",  32'(bus.inicio),  32'(0));
        rst_n = 1'b1;
        step();
        chk("rel_x_ready", 32'(bus.x_ready), 32'(1));

        // Single job A=1,B=2,C=2,x=2
        cfg_write(2'd0, 16'd1); cfg_write(2'd1, 16'd2); cfg_write(2'd2, 16'd2);
        i0 = n_inicio;
        push(16'd2);
        wait_yv(n);
        chk("t2_latency", 32'(n), 32'(10));
        chk("t2_y_data",  32'(bus.y_data), 32'(10));
        wait_idle();
        chk("t2_inicio_cnt", 32'(n_inicio - i0), 32'(1));

        // Backpressure hold
        bus.y_ready = 1'b0;
        i0 = n_inicio;
        push(16'd2);
        wait_yv(n);
        repeat (5) begin
            step();
            chk("t3_hold_v", 32'(bus.y_valid), 32'(1));
            chk("t3_hold_d", 32'(bus.y_data),  32'(10));
        end
        bus.y_ready = 1'b1;
        step();
        chk("t3_release", 32'(bus.y_valid), 32'(0));
        wait_idle();
        chk("t3_inicio_cnt", 32'(n_inicio - i0), 32'(1));

        // FIFO fill: one in flight plus four queued
        bus.y_ready = 1'b0;
        got.delete();
        for (int x = 1; x <= 5; x++) push(16'(x));
        bus.x_valid = 1'b1; bus.x_data = 16'd6;
        repeat (3) step();
        chk("t4_full",  32'(bus.x_ready), 32'(0));
        chk("t4_x_out", 32'(bus.x_out),   32'(1));
        bus.y_ready = 1'b1;
        push(16'd6);
        wait_idle();
        step();
        chk("t4_count", 32'(got.size()), 32'(6));
        for (int i = 0; i < 6; i++)
            if (i < got.size()) chk("t4_order", 32'(got[i]), 32'(exp4[i]));

        // Config write rules
        push(16'd1);
        repeat (2) step();
        cfg_write(2'd0, 16'd7);
        chk("t5_err_busy", 32'(bus.cfg_err), 32'(1));
        chk("t5_A_kept",   32'(bus.A_out),   32'(1));
        step();
        chk("t5_err_pulse", 32'(bus.cfg_err), 32'(0));
        wait_idle();
        cfg_write(2'd0, 16'd7);
        chk("t5_A_new",    32'(bus.A_out),   32'(7));
        chk("t5_err_idle", 32'(bus.cfg_err), 32'(0));
        cfg_write(2'd3, 16'd9);
        chk("t5_rsv_A",   32'(bus.A_out),   32'(7));
        chk("t5_rsv_B",   32'(bus.B_out),   32'(2));
        chk("t5_rsv_C",   32'(bus.C_out),   32'(2));
        chk("t5_rsv_err", 32'(bus.cfg_err), 32'(0));
        cfg_write(2'd0, 16'd1);

        // Reset mid-job
        push(16'd3);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        chk("t6_rst_busy", 32'(bus.busy),    32'(0));
        chk("t6_rst_yv",   32'(bus.y_valid), 32'(0));
        chk("t6_rst_A",    32'(bus.A_out),   32'(0));
        rst_n = 1'b1;
        step();
        chk("t6_rel_ready", 32'(bus.x_ready), 32'(1));
        n0 = nyv;
        cfg_write(2'd0, 16'd1); cfg_write(2'd1, 16'd2); cfg_write(2'd2, 16'd2);
        repeat (15) step();
        chk("t6_no_y", 32'(nyv - n0), 32'(0));
        push(16'd0);
        wait_yv(n);
        chk("t6_latency", 32'(n), 32'(10));
        chk("t6_y_data",  32'(bus.y_data), 32'(2));
        wait_idle();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.x_valid  = ($urandom_range(0, 1) == 1);
            bus.x_data   = 16'($urandom);
            bus.y_ready  = ($urandom_range(0, 9) < 7);
            bus.cfg_we   = ($urandom_range(0, 19) == 0);
            bus.cfg_addr = 2'($urandom);
            bus.cfg_data = 16'($urandom);
            rst_n        = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1;
        bus.x_valid = 0; bus.cfg_we = 0; bus.y_ready = 1'b1;
        wait_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
